// File: rtl/io_vga_ctrl_if.sv
// I/O bus seen by io_vga_ctrl: address, one-cycle strobes, write data and registered read data.
// Signal names keep the CPU-side view (port_o = CPU out, port_i = CPU in).
interface io_vga_ctrl_if;
  logic [15:0] port_a;
  logic        port_w;
  logic        port_r;
  logic [7:0]  port_o;
  logic [7:0]  port_i;

  modport master (
    output port_a,
    output port_w,
    output port_r,
    output port_o,
    input  port_i
  );

  modport slave (
    input  port_a,
    input  port_w,
    input  port_r,
    input  port_o,
    output port_i
  );
endinterface

// File: rtl/io_vga_ctrl.sv
// VGA I/O control: mode register, CRTC cursor registers and DAC palette programming.
// Palette readback (3C7 index, read FSM, data readback) is built only with IO_VGA_DAC_READ_EN.
module io_vga_ctrl #(
  parameter logic [15:0] PORT_DAC  = 16'h03C7,
  parameter logic [15:0] PORT_CRT  = 16'h03D4,
  parameter logic [15:0] PORT_MODE = 16'h03D8,
  parameter int unsigned CURSOR_W  = 12,
  parameter int unsigned DAC_AW    = 8
) (
  input  logic                clock,
  input  logic                reset,
  io_vga_ctrl_if.slave        bus,
  output logic                videomode,
  output logic [CURSOR_W-1:0] cursor,
  output logic [DAC_AW-1:0]   dac_a,
  output logic [15:0]         dac_d,
  output logic                dac_w,
  input  logic [15:0]         dac_q
);

  logic                hit_dac_ri, hit_dac_wi, hit_dac_d;
  logic                hit_crt_i, hit_crt_d, hit_mode;

  logic [7:0]          port_i_q, port_i_d;
  logic                videomode_q, videomode_d;
  logic [CURSOR_W-1:0] cursor_q, cursor_d;
  logic [4:0]          crt_idx_q, crt_idx_d;
  logic [DAC_AW-1:0]   wr_idx_q, wr_idx_d;
  logic [1:0]          phase_q, phase_d;
  logic [5:0]          red_q, red_d;
  logic [5:0]          grn_q, grn_d;
  logic                dac_w_q, dac_w_d;
  logic [DAC_AW-1:0]   dac_a_q, dac_a_d;
  logic [15:0]         dac_d_q, dac_d_d;
  logic [7:0]          cur_hi;
  logic [1:0]          wphase;

`ifdef IO_VGA_DAC_READ_EN
  typedef enum logic {DAC_WRITE, DAC_READ} dac_mode_e;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_READY} rd_state_e;

  dac_mode_e           mode_q, mode_d;
  rd_state_e           state_q, state_d;
  logic [DAC_AW-1:0]   rd_idx_q, rd_idx_d;
  logic [15:0]         rd_word_q, rd_word_d;
  logic [7:0]          rd_comp;
`else
  logic                unused_dac_q;
  assign unused_dac_q = ^dac_q;
`endif

  assign hit_dac_ri = (bus.port_a == PORT_DAC);
  assign hit_dac_wi = (bus.port_a == PORT_DAC + 16'd1);
  assign hit_dac_d  = (bus.port_a == PORT_DAC + 16'd2);
  assign hit_crt_i  = (bus.port_a == PORT_CRT);
  assign hit_crt_d  = (bus.port_a == PORT_CRT + 16'd1);
  assign hit_mode   = (bus.port_a == PORT_MODE);

`ifdef IO_VGA_DAC_READ_EN
  // 6-bit readback: 5-bit fields are widened by replicating their MSB.
  always_comb begin
    case (phase_q)
      2'd0:    rd_comp = {2'b00, rd_word_q[15:11], rd_word_q[15]};
      2'd1:    rd_comp = {2'b00, rd_word_q[10:5]};
      default: rd_comp = {2'b00, rd_word_q[4:0], rd_word_q[4]};
    endcase
  end
`endif

  always_comb begin
    port_i_d    = port_i_q;
    videomode_d = videomode_q;
    cursor_d    = cursor_q;
    crt_idx_d   = crt_idx_q;
    wr_idx_d    = wr_idx_q;
    phase_d     = phase_q;
    red_d       = red_q;
    grn_d       = grn_q;
    dac_w_d     = 1'b0;
    dac_a_d     = dac_a_q;
    dac_d_d     = dac_d_q;
    wphase      = phase_q;
    cur_hi      = '0;
    cur_hi[CURSOR_W-9:0] = cursor_q[CURSOR_W-1:8];
`ifdef IO_VGA_DAC_READ_EN
    mode_d    = mode_q;
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_word_d = rd_word_q;

    // A fetch colliding with a palette write pulse keeps FETCH and retries.
    case (state_q)
      S_FETCH: if (!dac_w_q) state_d = S_WAIT;
      S_WAIT: begin
        rd_word_d = dac_q;
        state_d   = S_READY;
      end
      default: ;
    endcase
`endif

    // Reads see pre-write state; write effects below override shared state.
    if (bus.port_r) begin
      port_i_d = 8'hFF;
      if (hit_mode) begin
        port_i_d = {7'b0, videomode_q};
      end else if (hit_crt_i) begin
        port_i_d = {3'b0, crt_idx_q};
      end else if (hit_crt_d) begin
        if (crt_idx_q == 5'h0E)      port_i_d = cur_hi;
        else if (crt_idx_q == 5'h0F) port_i_d = cursor_q[7:0];
      end else if (hit_dac_ri) begin
`ifdef IO_VGA_DAC_READ_EN
        port_i_d = (mode_q == DAC_READ) ? 8'h03 : 8'h00;
`else
        port_i_d = 8'h00;
`endif
      end else if (hit_dac_wi) begin
        port_i_d = 8'(wr_idx_q);
      end
`ifdef IO_VGA_DAC_READ_EN
      else if (hit_dac_d) begin
        port_i_d = rd_comp;
        if (mode_q == DAC_READ && state_q == S_READY) begin
          if (phase_q == 2'd2) begin
            phase_d  = 2'd0;
            rd_idx_d = rd_idx_q + DAC_AW'(1);
            state_d  = S_FETCH;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
`endif
    end

    if (bus.port_w) begin
      if (hit_mode) begin
        videomode_d = bus.port_o[0];
      end else if (hit_crt_i) begin
        crt_idx_d = bus.port_o[4:0];
      end else if (hit_crt_d) begin
        if (crt_idx_q == 5'h0E)      cursor_d[CURSOR_W-1:8] = bus.port_o[CURSOR_W-9:0];
        else if (crt_idx_q == 5'h0F) cursor_d[7:0] = bus.port_o;
      end else if (hit_dac_wi) begin
        wr_idx_d = DAC_AW'(bus.port_o);
        phase_d  = 2'd0;
`ifdef IO_VGA_DAC_READ_EN
        mode_d   = DAC_WRITE;
        state_d  = S_IDLE;
`endif
      end
`ifdef IO_VGA_DAC_READ_EN
      else if (hit_dac_ri) begin
        rd_idx_d = DAC_AW'(bus.port_o);
        phase_d  = 2'd0;
        mode_d   = DAC_READ;
        state_d  = S_FETCH;
      end
`endif
      else if (hit_dac_d) begin
`ifdef IO_VGA_DAC_READ_EN
        if (mode_q == DAC_READ) begin
          wphase  = 2'd0;
          mode_d  = DAC_WRITE;
          state_d = S_IDLE;
        end
`endif
        case (wphase)
          2'd0: begin
            red_d   = bus.port_o[5:0];
            phase_d = 2'd1;
          end
          2'd1: begin
            grn_d   = bus.port_o[5:0];
            phase_d = 2'd2;
          end
          default: begin
            dac_w_d  = 1'b1;
            dac_a_d  = wr_idx_q;
            dac_d_d  = {red_q[5:1], grn_q, bus.port_o[5:1]};
            wr_idx_d = wr_idx_q + DAC_AW'(1);
            phase_d  = 2'd0;
          end
        endcase
      end
    end

`ifdef IO_VGA_DAC_READ_EN
    if (!dac_w_d && state_d == S_FETCH) dac_a_d = rd_idx_d;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      port_i_q    <= 8'hFF;
      videomode_q <= 1'b0;
      cursor_q    <= '0;
      crt_idx_q   <= '0;
      wr_idx_q    <= '0;
      phase_q     <= '0;
      red_q       <= '0;
      grn_q       <= '0;
      dac_w_q     <= 1'b0;
      dac_a_q     <= '0;
      dac_d_q     <= '0;
    end else begin
      port_i_q    <= port_i_d;
      videomode_q <= videomode_d;
      cursor_q    <= cursor_d;
      crt_idx_q   <= crt_idx_d;
      wr_idx_q    <= wr_idx_d;
      phase_q     <= phase_d;
      red_q       <= red_d;
      grn_q       <= grn_d;
      dac_w_q     <= dac_w_d;
      dac_a_q     <= dac_a_d;
      dac_d_q     <= dac_d_d;
    end
  end

`ifdef IO_VGA_DAC_READ_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q    <= DAC_WRITE;
      state_q   <= S_IDLE;
      rd_idx_q  <= '0;
      rd_word_q <= '0;
    end else begin
      mode_q    <= mode_d;
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      rd_word_q <= rd_word_d;
    end
  end
`endif

  assign bus.port_i = port_i_q;
  assign videomode  = videomode_q;
  assign cursor     = cursor_q;
  assign dac_a      = dac_a_q;
  assign dac_d      = dac_d_q;
  assign dac_w      = dac_w_q;

endmodule

// File: tb/tb_io_vga_ctrl.sv
// Self-checking bench for io_vga_ctrl: vector table plus hand sequences for readback and reset.
// Read and palette-write expectations are queued when driven and compared when the DUT responds.
module tb_io_vga_ctrl;
  logic        clock;
  logic        rst;
  logic        videomode;
  logic [11:0] cursor;
  logic [7:0]  dac_a;
  logic [15:0] dac_d;
  logic        dac_w;
  logic [15:0] dac_q;

  io_vga_ctrl_if bus_if ();

  io_vga_ctrl #(
    .PORT_DAC (16'h03C7),
    .PORT_CRT (16'h03D4),
    .PORT_MODE(16'h03D8),
    .CURSOR_W (12),
    .DAC_AW   (8)
  ) dut (
    .clock    (clock),
    .reset    (rst),
    .bus      (bus_if),
    .videomode(videomode),
    .cursor   (cursor),
    .dac_a    (dac_a),
    .dac_d    (dac_d),
    .dac_w    (dac_w),
    .dac_q    (dac_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Palette RAM stand-in: data valid one cycle after the address.
  function automatic logic [15:0] pal_fn(input logic [7:0] a);
    if (a == 8'h10) return 16'hF810;
    return {a, ~a};
  endfunction

  always @(posedge clock) dac_q <= pal_fn(dac_a);

  typedef struct {
    string      name;
    logic [7:0] val;
  } rd_exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } dac_exp_t;

  typedef struct {
    logic        w;
    logic        r;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
    logic        dac_chk;
    logic [7:0]  exp_da;
    logic [15:0] exp_dd;
  } vec_t;

  rd_exp_t  rd_q[$];
  dac_exp_t dac_sb[$];
  vec_t     vecs[$];
  int       errors = 0;
  int       checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle; inputs change 1ns after the edge, responses checked 1ns after the next edge.
  task automatic bus_cycle(input logic w, input logic r, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] exp_rd, input string name);
    rd_exp_t  re;
    dac_exp_t de;
    bus_if.port_w = w;
    bus_if.port_r = r;
    bus_if.port_a = a;
    bus_if.port_o = d;
    if (r) rd_q.push_back('{name, exp_rd});
    @(posedge clock);
    #1;
    bus_if.port_w = 1'b0;
    bus_if.port_r = 1'b0;
    if (r) begin
      re = rd_q.pop_front();
      check(re.name, {24'b0, bus_if.port_i}, {24'b0, re.val});
    end
    if (dac_w) begin
      if (dac_sb.size() == 0) begin
        check("dac_w_unexpected", 32'(dac_w), 32'd0);
      end else begin
        de = dac_sb.pop_front();
        check("dac_a_on_write", {24'b0, dac_a}, {24'b0, de.a});
        check("dac_d_on_write", {16'b0, dac_d}, {16'b0, de.d});
      end
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_cycle(1'b1, 1'b0, a, d, 8'h00, "");
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    bus_cycle(1'b0, 1'b1, a, 8'h00, exp, name);
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, "");
  endtask

  task automatic add(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input logic dac_chk, input logic [7:0] da,
                     input logic [15:0] dd);
    vecs.push_back('{w, r, a, d, exp_rd, dac_chk, da, dd});
  endtask

  initial begin
    rst = 1'b1;
    bus_if.port_w = 1'b0;
    bus_if.port_r = 1'b0;
    bus_if.port_a = 16'h0000;
    bus_if.port_o = 8'h00;
    idle();
    idle();
    check("rst_port_i", {24'b0, bus_if.port_i}, 32'hFF);
    check("rst_videomode", 32'(videomode), 32'd0);
    check("rst_cursor", {20'b0, cursor}, 32'h000);
    check("rst_dac_w", 32'(dac_w), 32'd0);
    check("rst_dac_a", {24'b0, dac_a}, 32'h00);
    check("rst_dac_d", {16'b0, dac_d}, 32'h0000);
    rst = 1'b0;

    //   w     r     addr      data   exp_rd dac  exp_a  exp_d
    add(1'b1, 1'b0, 16'h03C8, 8'h10, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h3F, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h20, 8'h00, 1'b1, 8'h10, 16'hF810);
    add(1'b0, 1'b1, 16'h03C8, 8'h00, 8'h11, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b1, 16'h03C7, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03D4, 8'h0E, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03D5, 8'h07, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03D4, 8'h0F, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03D5, 8'hCF, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b1, 16'h03D5, 8'h00, 8'hCF, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03D4, 8'h0E, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b1, 16'h03D5, 8'h00, 8'h07, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03D4, 8'h05, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03D5, 8'hAA, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b1, 16'h03D5, 8'h00, 8'hFF, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b1, 16'h1234, 8'h00, 8'hFF, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C8, 8'hFF, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h01, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h02, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h03, 8'h00, 1'b1, 8'hFF, 16'h0041);
    add(1'b0, 1'b1, 16'h03C8, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h3F, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h3F, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C8, 8'h05, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h0A, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h0B, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03C9, 8'h0C, 8'h00, 1'b1, 8'h05, 16'h2966);
    add(1'b0, 1'b1, 16'h03C8, 8'h00, 8'h06, 1'b0, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 16'h03D8, 8'h01, 8'h00, 1'b0, 8'h00, 16'h0000);
    add(1'b0, 1'b1, 16'h03D8, 8'h00, 8'h01, 1'b0, 8'h00, 16'h0000);

    foreach (vecs[i]) begin
      if (vecs[i].dac_chk) dac_sb.push_back('{vecs[i].exp_da, vecs[i].exp_dd});
      bus_cycle(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp_rd,
                $sformatf("vec%0d_read", i));
    end

    check("videomode_set", 32'(videomode), 32'd1);
    check("cursor_7cf", {20'b0, cursor}, 32'h7CF);

    // Simultaneous write and read of the mode port returns the old value.
    bus_cycle(1'b1, 1'b1, 16'h03D8, 8'h00, 8'h01, "mode_rw_same_cycle");
    check("videomode_cleared", 32'(videomode), 32'd0);
    rd(16'h03D8, 8'h00, "mode_after_rw");

`ifdef IO_VGA_DAC_READ_EN
    wr(16'h03C7, 8'h10);
    check("fetch_addr", {24'b0, dac_a}, 32'h10);
    idle();
    idle();
    rd(16'h03C9, 8'h3F, "rd_r_10");
    rd(16'h03C9, 8'h00, "rd_g_10");
    rd(16'h03C9, 8'h21, "rd_b_10");
    check("prefetch_addr", {24'b0, dac_a}, 32'h11);
    rd(16'h03C9, 8'h3F, "stale_in_fetch");
    rd(16'h03C9, 8'h3F, "stale_in_wait");
    rd(16'h03C9, 8'h04, "rd_r_11");
    rd(16'h03C9, 8'h0F, "rd_g_11");
    rd(16'h03C9, 8'h1C, "rd_b_11");
    rd(16'h03C7, 8'h03, "status_read_mode");
    wr(16'h03C9, 8'h3F);
    wr(16'h03C9, 8'h3F);
    dac_sb.push_back('{8'h06, 16'hFFFF});
    wr(16'h03C9, 8'h3F);
    rd(16'h03C7, 8'h00, "status_back_to_write");
    rd(16'h03C8, 8'h07, "wr_idx_after_switch");
`else
    wr(16'h03C7, 8'h10);
    rd(16'h03C7, 8'h00, "status_no_read");
    rd(16'h03C9, 8'hFF, "data_read_disabled");
    check("dac_a_hold", {24'b0, dac_a}, 32'h05);
`endif

    // Reset lands on the cycle of the third data write: no pulse, all state cleared.
    wr(16'h03D8, 8'h01);
    wr(16'h03C8, 8'h30);
    wr(16'h03C9, 8'h01);
    wr(16'h03C9, 8'h02);
    rst = 1'b1;
    wr(16'h03C9, 8'h03);
    rst = 1'b0;
    check("rst_mid_dac_w", 32'(dac_w), 32'd0);
    check("rst_mid_port_i", {24'b0, bus_if.port_i}, 32'hFF);
    check("rst_mid_videomode", 32'(videomode), 32'd0);
    check("rst_mid_cursor", {20'b0, cursor}, 32'h000);
    check("rst_mid_dac_a", {24'b0, dac_a}, 32'h00);
    check("rst_mid_dac_d", {16'b0, dac_d}, 32'h0000);
    idle();
    check("rst_mid_no_late_pulse", 32'(dac_w), 32'd0);
    rd(16'h03C8, 8'h00, "rst_mid_wr_idx");
    rd(16'h03C7, 8'h00, "rst_mid_status");
    wr(16'h03C9, 8'h3F);
    wr(16'h03C9, 8'h3F);
    dac_sb.push_back('{8'h00, 16'hFFFF});
    wr(16'h03C9, 8'h3F);
    idle();
    check("dac_w_one_cycle", 32'(dac_w), 32'd0);

    check("dac_w_missing", 32'(dac_sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_vga_ctrl.md
Name: io_vga_ctrl

Overview:
- Port-mapped VGA control block between the core's I/O bus and the video/palette resources.
- Owns the video mode register, the CRTC cursor registers (0Eh/0Fh) and the VGA DAC programming protocol (3C7/3C8/3C9).
- The DAC protocol is sequenced as a state machine: RGB byte triplets are packed into 16-bit palette words for the mem_dac palette RAM.
- Generalises the previously hard-wired videomode/cursor/DAC wiring to parametrised port bases, cursor width and palette depth.

Parameters:
PORT_DAC, 16'h03C7, base of DAC ports; read index at +0, write index at +1, data at +2
PORT_CRT, 16'h03D4, CRTC index port; data port at +1
PORT_MODE, 16'h03D8, mode register port; bit0 = videomode
CURSOR_W, 12, cursor width; range 9..16
DAC_AW, 8, palette address width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
port_a  in  16  I/O address
port_w  in  1  I/O write strobe, one cycle
port_r  in  1  I/O read strobe, one cycle
port_o  in  8  CPU write data
port_i  out  8  read data, registered
videomode  out  1  0 = text, 1 = 320x200
cursor  out  CURSOR_W  cursor position
dac_a  out  DAC_AW  palette address
dac_d  out  16  palette write word, RGB565
dac_w  out  1  palette write pulse
dac_q  in  16  palette read word; valid 1 cycle after dac_a is presented

Behaviour:
- Interface: single clock `clock`; `reset` is synchronous and active-high.
- Reset values: port_i=FFh, videomode=0, cursor=0, dac_a=0, dac_d=0, dac_w=0, CRTC index=0, write index=0, read index=0, phase=0, DAC state=write mode, FSM=IDLE.
- Reads: port_i updates on the cycle after port_r and holds until the next port_r. Unmapped addresses return FFh.
- PORT_MODE: write sets videomode=port_o[0]; read returns {7'b0, videomode}.
- CRTC: write to PORT_CRT latches a 5-bit index. Write to PORT_CRT+1 with index 0Eh sets cursor[CURSOR_W-1:8]=port_o[CURSOR_W-9:0]; index 0Fh sets cursor[7:0]. Other indices are ignored; their reads return FFh. The cursor output updates one cycle after the write.
- DAC write path:
  - Write to PORT_DAC+1: wr_idx=port_o, phase=0, state=write mode.
  - Writes to PORT_DAC+2 latch R, G, B (6 bits each, port_o[5:0]) for phase 0, 1, 2.
  - On the phase-2 write, the next cycle has dac_w=1 for exactly one cycle, dac_a=wr_idx, dac_d={R[5:1],G[5:0],B[5:1]}. Then wr_idx increments (wraps to 0 after 2^DAC_AW−1) and phase=0.
- DAC read FSM: IDLE -> FETCH -> WAIT -> READY.
  - Write to PORT_DAC: rd_idx=port_o, phase=0, state=read mode, FSM=FETCH.
  - FETCH drives dac_a=rd_idx. WAIT latches dac_q the next cycle. READY is then entered.
  - Reads of PORT_DAC+2 in READY return {2'b0,R5,R5[4]}, {2'b0,G6} and {2'b0,B5,B5[4]} for phase 0, 1, 2.
  - After the phase-2 read, rd_idx increments (with wrap), phase=0 and FSM=FETCH (prefetch).
  - A data read while in FETCH/WAIT returns the stale latch and does not advance the phase.
- Status reads: PORT_DAC read returns 00h in write mode and 03h in read mode. PORT_DAC+1 read returns wr_idx.
- Palette-address conflict: a dac_w cycle has priority on dac_a. A FETCH that collides with it holds for one cycle and retries.
- Simultaneous port_w and port_r: both are processed. The read returns the pre-write value.
- Mid-sequence interruptions:
  - A write to an index port mid-triplet discards the partial triplet.
  - A write to PORT_DAC+2 in read mode switches to write mode at wr_idx, phase=0, before latching.
- Reset mid-operation: immediate return to reset values. A pending dac_w is suppressed.

Optional Feature:
- Macro: IO_VGA_DAC_READ_EN.
- Defined: the read FSM, PORT_DAC index writes and the readback path behave as above.
- Undefined: no read FSM. Writes to PORT_DAC are ignored, PORT_DAC+2 reads return FFh, PORT_DAC reads return 00h, and dac_a is driven only by the write path.

Test Plan:
- Reset -> port_i=FFh, videomode=0, cursor=000h, dac_w=0.
- OUT 3C8←10h; OUT 3C9←3Fh,00h,20h -> one dac_w pulse with dac_a=10h, dac_d=F810h; a following IN 3C8 returns 11h.
- OUT 3D4←0Eh, 3D5←07h, 3D4←0Fh, 3D5←CFh -> cursor=7CFh. OUT 3D8←01h -> videomode=1.
- OUT 3C7←10h; wait 3 cycles with dac_q=F810h; IN 3C9 ×3 -> 3Fh, 00h, 21h; dac_a=11h is issued for the prefetch.
- Write index FFh, full triplet -> write lands at FFh and wr_idx wraps to 00h. Two 3C9 writes then OUT 3C8←05h -> no dac_w; the next triplet writes to 05h.
- Assert reset while phase=2 and the third write strobe is in flight -> no dac_w pulse; all registers at reset values.
